// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bundle between the timing source and the pixel generator
interface video_timing_gen_if;
    logic        en;
    logic [15:0] x;
    logic [15:0] y;
    logic        vde;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        input  en,
        output x, y, vde, hsync, vsync, line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  x, y, vde, hsync, vsync, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing source: x/y counters, phase FSMs, syncs, vde and frame pulses
module video_timing_gen #(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int H_SYNC_TIME = 44,
    parameter int V_SYNC_TIME = 5,
    parameter int H_F_PORCH   = 88,
    parameter int V_F_PORCH   = 4,
    parameter int H_B_PORCH   = 148,
    parameter int V_B_PORCH   = 36,
    parameter int H_SYNC_POL  = 1,
    parameter int V_SYNC_POL  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    video_timing_gen_if.master    vt
);
    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BACK_PORCH,
        PH_ACTIVE,
        PH_FRONT_PORCH
    } phase_t;

    localparam logic [15:0] H_TOTAL     = 16'(H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH);
    localparam logic [15:0] V_TOTAL     = 16'(V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH);
    localparam logic [15:0] H_BP_START  = 16'(H_SYNC_TIME);
    localparam logic [15:0] H_ACT_START = 16'(H_SYNC_TIME + H_B_PORCH);
    localparam logic [15:0] H_FP_START  = 16'(H_SYNC_TIME + H_B_PORCH + WIDTH);
    localparam logic [15:0] V_BP_START  = 16'(V_SYNC_TIME);
    localparam logic [15:0] V_ACT_START = 16'(V_SYNC_TIME + V_B_PORCH);
    localparam logic [15:0] V_FP_START  = 16'(V_SYNC_TIME + V_B_PORCH + HEIGHT);
    localparam logic        H_POL       = 1'(H_SYNC_POL);
    localparam logic        V_POL       = 1'(V_SYNC_POL);

    phase_t      h_state, h_nxt;
    phase_t      v_state, v_nxt;
    logic [15:0] x_q, x_nxt;
    logic [15:0] y_q, y_nxt;
    logic [15:0] fc_q, fc_nxt;
    logic        vde_q, vde_nxt;
    logic        hsync_q, hsync_nxt;
    logic        vsync_q, vsync_nxt;
    logic        ls_q, ls_nxt;
    logic        fs_q, fs_nxt;
    logic        x_wrap;

    // A phase is left when the upcoming position lands on the next phase's first count.
    function automatic phase_t next_phase(input phase_t cur, input logic [15:0] pos,
                                          input logic [15:0] bp, input logic [15:0] act,
                                          input logic [15:0] fp);
        phase_t n;
        n = cur;
        case (cur)
            PH_SYNC:        if (pos == bp)    n = PH_BACK_PORCH;
            PH_BACK_PORCH:  if (pos == act)   n = PH_ACTIVE;
            PH_ACTIVE:      if (pos == fp)    n = PH_FRONT_PORCH;
            PH_FRONT_PORCH: if (pos == 16'd0) n = PH_SYNC;
            default:        n = PH_FRONT_PORCH;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            h_state <= PH_FRONT_PORCH;
            v_state <= PH_FRONT_PORCH;
            x_q     <= H_TOTAL - 16'd1;
            y_q     <= V_TOTAL - 16'd1;
            fc_q    <= 16'hFFFF;
            vde_q   <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_state <= h_nxt;
            v_state <= v_nxt;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            fc_q    <= fc_nxt;
            vde_q   <= vde_nxt;
            hsync_q <= hsync_nxt;
            vsync_q <= vsync_nxt;
            ls_q    <= ls_nxt;
            fs_q    <= fs_nxt;
        end
    end

    always_comb begin
        x_nxt  = x_q;
        y_nxt  = y_q;
        h_nxt  = h_state;
        v_nxt  = v_state;
        fc_nxt = fc_q;
        ls_nxt = 1'b0;
        fs_nxt = 1'b0;
        x_wrap = (x_q == H_TOTAL - 16'd1);
        if (vt.en) begin
            x_nxt = x_wrap ? 16'd0 : x_q + 16'd1;
            h_nxt = next_phase(h_state, x_nxt, H_BP_START, H_ACT_START, H_FP_START);
            if (x_wrap) begin
                y_nxt = (y_q == V_TOTAL - 16'd1) ? 16'd0 : y_q + 16'd1;
                v_nxt = next_phase(v_state, y_nxt, V_BP_START, V_ACT_START, V_FP_START);
            end
            ls_nxt = x_wrap;
            fs_nxt = x_wrap && (y_nxt == 16'd0);
            if (fs_nxt) fc_nxt = fc_q + 16'd1;
        end
        // Decode from the next phase so syncs and vde share the counters' register stage.
        hsync_nxt = (h_nxt == PH_SYNC) ? H_POL : ~H_POL;
        vsync_nxt = (v_nxt == PH_SYNC) ? V_POL : ~V_POL;
        vde_nxt   = (h_nxt == PH_ACTIVE) && (v_nxt == PH_ACTIVE);
    end

    assign vt.x           = x_q;
    assign vt.y           = y_q;
    assign vt.vde         = vde_q;
    assign vt.hsync       = hsync_q;
    assign vt.vsync       = vsync_q;
    assign vt.line_start  = ls_q;
    assign vt.frame_start = fs_q;
    assign vt.frame_count = fc_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized and directed checks of video_timing_gen against a position model
module tb_video_timing_gen;
    localparam int W = 8, H = 4, HS = 2, HB = 3, HF = 1, VS = 1, VB = 2, VF = 1;
    localparam int HT = HS + HB + W + HF;
    localparam int VT = VS + VB + H + VF;

    logic clk;
    logic rst;
    logic en;
    int   tests;
    int   fails;

    video_timing_gen_if vt_p ();
    video_timing_gen_if vt_n ();
    assign vt_p.en = en;
    assign vt_n.en = en;

    video_timing_gen #(.WIDTH(W), .HEIGHT(H), .H_SYNC_TIME(HS), .V_SYNC_TIME(VS),
        .H_F_PORCH(HF), .V_F_PORCH(VF), .H_B_PORCH(HB), .V_B_PORCH(VB),
        .H_SYNC_POL(1), .V_SYNC_POL(1)) dut_p (.clk(clk), .rst(rst), .vt(vt_p));

    video_timing_gen #(.WIDTH(W), .HEIGHT(H), .H_SYNC_TIME(HS), .V_SYNC_TIME(VS),
        .H_F_PORCH(HF), .V_F_PORCH(VF), .H_B_PORCH(HB), .V_B_PORCH(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0)) dut_n (.clk(clk), .rst(rst), .vt(vt_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raster position plus pulse flags, updated from the inputs seen at each edge.
    int          mx, my;
    logic [15:0] mfc;
    logic        mls, mfs;
    bit          model_valid;

    always @(posedge clk) begin
        if (rst) begin
            mx = HT - 1; my = VT - 1; mfc = 16'hFFFF; mls = 0; mfs = 0;
            model_valid = 1;
        end else if (en) begin
            mx = (mx + 1) % HT;
            if (mx == 0) my = (my + 1) % VT;
            mls = (mx == 0);
            mfs = (mx == 0) && (my == 0);
            if (mfs) mfc = mfc + 16'd1;
        end else begin
            mls = 0; mfs = 0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            logic ehs, evs, evde;
            ehs  = (mx < HS);
            evs  = (my < VS);
            evde = (mx >= HS + HB) && (mx < HS + HB + W) && (my >= VS + VB) && (my < VS + VB + H);
            check("x", vt_p.x, 16'(mx));
            check("y", vt_p.y, 16'(my));
            check("vde", 16'(vt_p.vde), 16'(evde));
            check("hsync", 16'(vt_p.hsync), 16'(ehs));
            check("vsync", 16'(vt_p.vsync), 16'(evs));
            check("line_start", 16'(vt_p.line_start), 16'(mls));
            check("frame_start", 16'(vt_p.frame_start), 16'(mfs));
            check("frame_count", vt_p.frame_count, mfc);
            check("hsync_n", 16'(vt_n.hsync), 16'(!ehs));
            check("vsync_n", 16'(vt_n.vsync), 16'(!evs));
            check("x_n", vt_n.x, 16'(mx));
        end
    end

    task automatic drive(input logic r, input logic e);
        rst = r;
        en  = e;
        @(negedge clk);
    endtask

    task automatic adv_until(input int tx, input int ty);
        int n;
        n = 0;
        while (!(vt_p.x == 16'(tx) && vt_p.y == 16'(ty)) && n < 4 * HT * VT) begin
            drive(0, 1);
            n++;
        end
        check("reach_position", 16'(n < 4 * HT * VT), 16'd1);
    endtask

    int vde_cnt[3], hs_cnt[3], vs_cnt[3];
    int fs_cnt, first_vx, first_vy;

    initial begin
        tests = 0; fails = 0; model_valid = 0;
        rst = 1; en = 0;
        @(negedge clk);
        drive(1, 0); drive(1, 0); drive(1, 0);
        check("rst_x", vt_p.x, 16'd13);
        check("rst_y", vt_p.y, 16'd7);
        check("rst_fc", vt_p.frame_count, 16'hFFFF);
        check("rst_hsync_n", 16'(vt_n.hsync), 16'd1);
        check("rst_vsync_n", 16'(vt_n.vsync), 16'd1);

        drive(0, 1);
        check("t1_x", vt_p.x, 16'd0);
        check("t1_y", vt_p.y, 16'd0);
        check("t1_ls", 16'(vt_p.line_start), 16'd1);
        check("t1_fs", 16'(vt_p.frame_start), 16'd1);
        check("t1_hsync", 16'(vt_p.hsync), 16'd1);
        check("t1_vsync", 16'(vt_p.vsync), 16'd1);
        check("t1_vde", 16'(vt_p.vde), 16'd0);
        check("t1_fc", vt_p.frame_count, 16'd0);

        // Three frames from a fresh reset: per-frame tallies.
        drive(1, 0);
        fs_cnt = 0; first_vx = -1; first_vy = -1;
        for (int f = 0; f < 3; f++) begin vde_cnt[f] = 0; hs_cnt[f] = 0; vs_cnt[f] = 0; end
        for (int i = 0; i < 3 * HT * VT; i++) begin
            int f;
            drive(0, 1);
            f = i / (HT * VT);
            if (vt_p.vde) begin
                vde_cnt[f]++;
                if (first_vx < 0) begin first_vx = int'(vt_p.x); first_vy = int'(vt_p.y); end
            end
            if (vt_p.hsync) hs_cnt[f]++;
            if (vt_p.vsync) vs_cnt[f]++;
            if (vt_p.frame_start) begin
                fs_cnt++;
                check("t2_fs_spacing", 16'(i % (HT * VT)), 16'd0);
                check("t2_fc_seq", vt_p.frame_count, 16'(f));
            end
        end
        check("t2_fs_count", 16'(fs_cnt), 16'd3);
        check("t2_first_vde_x", 16'(first_vx), 16'd5);
        check("t2_first_vde_y", 16'(first_vy), 16'd3);
        for (int f = 0; f < 3; f++) begin
            check("t2_vde_per_frame", 16'(vde_cnt[f]), 16'd32);
            check("t2_hsync_per_frame", 16'(hs_cnt[f]), 16'd16);
            check("t2_vsync_per_frame", 16'(vs_cnt[f]), 16'd14);
        end

        // Freeze at x=7.
        adv_until(7, 4);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0);
            check("t4_hold_x", vt_p.x, 16'd7);
            check("t4_hold_y", vt_p.y, 16'd4);
            check("t4_hold_vde", 16'(vt_p.vde), 16'd1);
            check("t4_no_ls", 16'(vt_p.line_start), 16'd0);
        end
        drive(0, 1);
        check("t4_resume_x", vt_p.x, 16'd8);

        // Reset mid-active, with en still high.
        adv_until(5, 3);
        check("t5_pre_vde", 16'(vt_p.vde), 16'd1);
        drive(1, 1);
        check("t5_x", vt_p.x, 16'd13);
        check("t5_y", vt_p.y, 16'd7);
        check("t5_vde", 16'(vt_p.vde), 16'd0);
        check("t5_fc", vt_p.frame_count, 16'hFFFF);
        drive(0, 1);
        check("t5_rel_x", vt_p.x, 16'd0);
        check("t5_rel_fs", 16'(vt_p.frame_start), 16'd1);
        check("t5_rel_fc", vt_p.frame_count, 16'd0);

        // Random en gaps and occasional resets, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
